weight_pattern_gen: RTL and testbench
=====================================

Name: weight_pattern_gen

Overview:
- Inverse of the team's 4-input ones-count encoder.
- Accepts a one-hot weight code (weight k in 0..N) and emits every N-bit pattern whose popcount is k, one per accepted output beat, in ascending numeric order.
- Used to drive exhaustive stimulus into, and self-check of, the ones-count encoder path in silicon.
- Valid/ready on both sides; illegal (non-one-hot) weight codes are flagged and dropped.

Parameters:
- N, 4, pattern width; the weight input is N+1 bits. Legal range 2..8.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-high; clears all state on the clock edge it is sampled.
- in_weight  input  N+1  one-hot weight; bit k set means weight k (bit 0 = zero ones, bit N = all ones).
- in_valid  input  1  in_weight is valid this cycle.
- in_ready  output  1  block can accept a weight; high only in IDLE.
- out_pattern  output  N  current pattern; popcount equals the accepted k.
- out_index  output  N  ordinal of out_pattern within the sequence, starting at 0.
- out_last  output  1  out_pattern is the final pattern for this weight.
- out_valid  output  1  out_pattern/out_index/out_last are valid.
- out_ready  input  1  consumer takes the beat when out_valid && out_ready.
- err  output  1  one-cycle pulse: accepted in_weight was not one-hot.

Behaviour:
- Reset values:
  - state = IDLE, in_ready = 1, out_valid = 0, out_last = 0, err = 0.
  - out_pattern = 0, out_index = 0.
  - Reset asserted mid-sequence aborts it; no further beats are emitted.
- States:
  - IDLE: in_ready = 1. On in_valid at edge t, the weight is accepted.
  - EMIT: in_ready = 0; new weights are not accepted.
- Accepting a legal weight at edge t:
  - Decode k; the block enters EMIT.
  - From cycle t+1: out_valid = 1, out_pattern = (1<<k)-1, out_index = 0.
  - out_last = 1 when only one pattern exists (k = 0 or k = N).
- Accepting an illegal weight at edge t:
  - Illegal means zero bits set or more than one bit set.
  - Cycle t+1: err = 1 for exactly one cycle, state stays IDLE, in_ready stays 1, no output beat.
  - A legal weight presented during the err cycle is accepted normally.
- Handshake in EMIT:
  - While out_valid && !out_ready, all out_* are held stable (no change, no glitch).
  - On a beat with out_last = 0: next cycle, out_pattern = next combination (Gosper step), out_index increments, out_last is recomputed.
  - out_last = 1 exactly when out_pattern equals the top k bits set, i.e. ((1<<k)-1) << (N-k).
  - On a beat with out_last = 1: next cycle, state = IDLE, out_valid = 0, in_ready = 1.
- Back-to-back sequences: one bubble cycle between the last beat and the next first beat. Minimum latency from acceptance to first pattern is 1 cycle.
- Throughput: one pattern per cycle while out_ready is held high. Sequence length is C(N,k); for N=4 the counts are 1,4,6,4,1.
- Arithmetic:
  - Gosper next = ((p ^ r) >> (tz+2)) | r, where lowbit = p & -p, r = p + lowbit, tz = trailing zeros of p.
  - Computed in N+1 bits; the result is never used after out_last.
  - k = 0 yields pattern 0, handled without Gosper.
- Output changes are registered only; no combinational path from in_* to out_*, and none from out_ready to out_*. in_ready depends only on state.

Decomposition:
- Shared package weight_pkg:
  - State enum {IDLE, EMIT}.
  - Default N = 4.
  - Functions onehot_legal(), onehot_to_k(), first_pattern(k), last_pattern(k), popcount().
  - The bench reuses popcount() as its scoreboard reference.
- One sub-module, weight_next_comb: purely combinational Gosper successor, input N-bit pattern, output N-bit next pattern. Unit-testable on its own.

Test Plan:
- Weight 00100 (k=2), out_ready held 1 -> beats 0011,0101,0110,1001,1010,1100 on consecutive cycles; index 0..5; out_last only on 1100; in_ready back to 1 on the following cycle.
- Weight 00001 (k=0), then 10000 (k=4) -> single beat 0000 with out_last=1, one bubble cycle, then single beat 1111 with out_last=1.
- Weight 00010 (k=1), out_ready toggling 1,0,0,1,1,0,1 -> sequence 0001,0010,0100,1000 with no drop or duplicate; outputs stable through every stall cycle.
- Illegal weights 00000, then 01100 -> err pulses one cycle each, no out_valid, in_ready stays 1; a following 01000 (k=3) yields 0111,1011,1101,1110.
- k=2 sequence with reset asserted on the third beat's cycle -> next cycle out_valid=0 and in_ready=1; a subsequent 00100 restarts at 0011 with index 0.
- Random legal/illegal weights with random out_ready, 10k cycles -> per sequence, count = C(4,k), all patterns have popcount k, strictly ascending, and no in_ready while in EMIT.

Source files
------------

// File: rtl/weight_pkg.sv
// Shared types and weight/pattern helpers for the weight pattern generator.
// Helpers operate at the widest legal width and take the pattern width as an argument.
package weight_pkg;

  localparam int unsigned DEF_N = 4;
  localparam int unsigned MAX_N = 8;
  localparam int unsigned KW    = 4;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  typedef logic [MAX_N:0] wide_t;

  function automatic logic [KW-1:0] popcount(input wide_t v);
    logic [KW-1:0] c;
    c = '0;
    for (int i = 0; i <= int'(MAX_N); i++) c = c + KW'(v[i]);
    return c;
  endfunction

  function automatic logic onehot_legal(input wide_t v);
    return popcount(v) == KW'(1);
  endfunction

  function automatic logic [KW-1:0] onehot_to_k(input wide_t v);
    logic [KW-1:0] k;
    k = '0;
    for (int i = 0; i <= int'(MAX_N); i++) if (v[i]) k = KW'(i);
    return k;
  endfunction

  // Lowest k bits set: the first pattern of weight k.
  function automatic wide_t first_pattern(input logic [KW-1:0] k);
    wide_t p;
    p = '0;
    for (int i = 0; i < int'(MAX_N); i++) if (KW'(i) < k) p[i] = 1'b1;
    return p;
  endfunction

  // Highest k bits of an n-bit field set: the final pattern of weight k.
  function automatic wide_t last_pattern(input logic [KW-1:0] k, input int unsigned n);
    return first_pattern(k) << (KW'(n) - k);
  endfunction

endpackage

// File: rtl/weight_next_comb.sv
// Combinational Gosper successor: next larger value with the same popcount.
// Evaluated one bit wider than the pattern; the carry-out only matters past the last pattern.
module weight_next_comb
  import weight_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic [N-1:0] pattern,
  output logic [N-1:0] next_pattern_c
);

  localparam int unsigned W  = N + 1;
  localparam int unsigned TW = 4;

  logic [W-1:0]  p;
  logic [W-1:0]  lowbit;
  logic [W-1:0]  r;
  logic [W-1:0]  nxt;
  logic [TW-1:0] tz;

  always_comb begin
    p      = {1'b0, pattern};
    lowbit = p & (~p + W'(1));
    r      = p + lowbit;
    tz     = '0;
    for (int i = int'(N) - 1; i >= 0; i--) if (pattern[i]) tz = TW'(i);
    nxt            = ((p ^ r) >> (tz + TW'(2))) | r;
    next_pattern_c = nxt[N-1:0];
  end

endmodule

// File: rtl/weight_pattern_gen.sv
// Expands a one-hot weight code into every N-bit pattern of that popcount, ascending,
// one per valid/ready beat; non-one-hot codes raise a one-cycle err and are dropped.
module weight_pattern_gen
  import weight_pkg::*;
#(
  parameter int unsigned N = DEF_N
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N:0]   in_weight,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [N-1:0] out_pattern,
  output logic [N-1:0] out_index,
  output logic         out_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic         err
);

  state_t          state_q, state_d;
  logic [N-1:0]    pat_q, pat_d;
  logic [N-1:0]    idx_q, idx_d;
  logic            last_q, last_d;
  logic [KW-1:0]   k_q, k_d;
  logic            err_q, err_d;

  wide_t           w_ext;
  logic            in_legal;
  logic [KW-1:0]   in_k;
  logic [N-1:0]    first_pat;
  logic [N-1:0]    next_c;

  assign w_ext     = wide_t'(in_weight);
  assign in_legal  = onehot_legal(w_ext);
  assign in_k      = onehot_to_k(w_ext);
  assign first_pat = N'(first_pattern(in_k));

  weight_next_comb #(.N(N)) u_next (
    .pattern        (pat_q),
    .next_pattern_c (next_c)
  );

  // State register and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pat_q   <= '0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    idx_d   = idx_q;
    last_d  = last_q;
    k_d     = k_q;
    err_d   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          if (in_legal) begin
            state_d = EMIT;
            k_d     = in_k;
            pat_d   = first_pat;
            idx_d   = '0;
            last_d  = (first_pat == N'(last_pattern(in_k, N)));
          end else begin
            err_d = 1'b1;
          end
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            last_d  = 1'b0;
          end else begin
            pat_d  = next_c;
            idx_d  = idx_q + N'(1);
            last_d = (next_c == N'(last_pattern(k_q, N)));
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == EMIT);
  assign out_pattern = pat_q;
  assign out_index   = idx_q;
  assign out_last    = last_q;
  assign err         = err_q;

endmodule

// File: tb/tb_weight_pattern_gen.sv
// Directed and randomized bench for weight_pattern_gen against an enumerate-and-filter model.
module tb_weight_pattern_gen;
  import weight_pkg::*;

  localparam int unsigned N  = DEF_N;
  localparam int unsigned WW = N + 1;

  logic         clk       = 1'b0;
  logic         reset     = 1'b1;
  logic [N:0]   in_weight = '0;
  logic         in_valid  = 1'b0;
  logic         out_ready = 1'b0;
  logic         in_ready;
  logic [N-1:0] out_pattern;
  logic [N-1:0] out_index;
  logic         out_last;
  logic         out_valid;
  logic         err;

  int          tests = 0;
  int          fails = 0;
  int unsigned cyc   = 0;
  logic        rdy_tab [0:6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  weight_pattern_gen #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_weight   (in_weight),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_pattern (out_pattern),
    .out_index   (out_index),
    .out_last    (out_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #(5_000_000);
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int binom(input int n, input int k);
    int r;
    r = 1;
    for (int i = 1; i <= k; i++) r = r * (n - k + i) / i;
    return r;
  endfunction

  task automatic accept(input logic [N:0] w);
    check("accept_ready", 32'(in_ready), 32'd1);
    in_weight = w;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
    in_weight = '0;
  endtask

  // Called one cycle after acceptance; mode 0 ready high, 1 fixed toggle table, 2 random.
  task automatic expect_seq(input int k, input int mode);
    int    q[$];
    int    n;
    int    cycles;
    logic  rdy;
    wide_t vw;
    n      = 0;
    cycles = 0;
    for (int v = 0; v < (1 << N); v++) begin
      vw = v[MAX_N:0];
      if (popcount(vw) == KW'(k)) q.push_back(v);
    end
    check("seq_len", 32'(q.size()), 32'(binom(int'(N), k)));
    while (n < q.size() && cycles < 200) begin
      check("valid", 32'(out_valid), 32'd1);
      check("in_ready_emit", 32'(in_ready), 32'd0);
      check("pattern", 32'(out_pattern), 32'(q[n]));
      check("index", 32'(out_index), 32'(n));
      check("last", 32'(out_last), 32'(n == q.size() - 1));
      check("popcount", 32'(popcount(wide_t'(out_pattern))), 32'(k));
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (cycles < 7) ? rdy_tab[cycles] : 1'b1;
        default: rdy = ($urandom_range(0, 3) != 0);
      endcase
      out_ready = rdy;
      tick();
      cycles++;
      if (rdy) n++;
    end
    out_ready = 1'b0;
    check("seq_done", 32'(n), 32'(q.size()));
    check("idle_valid", 32'(out_valid), 32'd0);
    check("idle_ready", 32'(in_ready), 32'd1);
    check("idle_last", 32'(out_last), 32'd0);
  endtask

  task automatic expect_err();
    check("err_pulse", 32'(err), 32'd1);
    check("err_valid", 32'(out_valid), 32'd0);
    check("err_ready", 32'(in_ready), 32'd1);
  endtask

  initial begin
    logic [N:0] w;
    int         k;
    logic       legal;

    reset = 1'b1;
    repeat (2) tick();
    check("rst_ready", 32'(in_ready), 32'd1);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_last", 32'(out_last), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_pattern", 32'(out_pattern), 32'd0);
    check("rst_index", 32'(out_index), 32'd0);
    reset = 1'b0;
    tick();

    // k=2 full sequence at full throughput
    accept(5'b00100);
    expect_seq(2, 0);

    // single-pattern weights back to back
    accept(5'b00001);
    expect_seq(0, 0);
    accept(5'b10000);
    expect_seq(4, 0);

    // k=1 with stalls
    accept(5'b00010);
    expect_seq(1, 1);

    // illegal codes, then a legal one presented during the err cycle
    accept(5'b00000);
    expect_err();
    accept(5'b01100);
    expect_err();
    accept(5'b01000);
    check("err_cleared", 32'(err), 32'd0);
    expect_seq(3, 0);

    // reset on the third beat of a k=2 sequence
    accept(5'b00100);
    out_ready = 1'b1;
    tick();
    tick();
    check("pre_rst_pattern", 32'(out_pattern), 32'h6);
    check("pre_rst_index", 32'(out_index), 32'd2);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b0;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_ready", 32'(in_ready), 32'd1);
    check("midrst_pattern", 32'(out_pattern), 32'd0);
    check("midrst_index", 32'(out_index), 32'd0);
    accept(5'b00100);
    expect_seq(2, 0);

    // randomized weights and consumer back-pressure
    while (cyc < 10000) begin
      if ($urandom_range(0, 3) == 0) begin
        tick();
        check("gap_err", 32'(err), 32'd0);
        check("gap_valid", 32'(out_valid), 32'd0);
      end else begin
        if ($urandom_range(0, 2) != 0) w = WW'(1) << $urandom_range(0, N);
        else                           w = WW'($urandom_range(0, (1 << WW) - 1));
        legal = (popcount(wide_t'(w)) == KW'(1));
        k = 0;
        for (int i = 0; i <= int'(N); i++) if (w[i]) k = i;
        accept(w);
        if (legal) begin
          check("rand_err", 32'(err), 32'd0);
          expect_seq(k, 2);
        end else begin
          expect_err();
        end
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
